mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus port between two requesters: the fetch stage (instruction request, read-only) and the memory stage (LD/SD data request).
- Latches the winning request, holds it on the bus until the bus acknowledges, then routes the one-cycle response back to the owner.
- Data requests win by default because they come from the older instruction. A streak counter stops fetch from starving.
- A fetch abort from branch/JALR redirect drops a stale instruction response without breaking the bus transaction.

Parameters:
- MAX_D_STREAK, 4: number of consecutive data grants allowed while a fetch is waiting; the next grant then goes to fetch. Range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  fetch request; held until iresp_ok or i_abort
- ireq_addr  in  64  fetch address (PC)
- i_abort  in  1  fetch redirect; kills the pending or in-flight fetch
- iresp_ok  out  1  one-cycle pulse: instruction response valid
- iresp_data  out  32  fetched instruction
- dreq_valid  in  1  data request; held until dresp_ok
- dreq_addr  in  64  data address
- dreq_size  in  3  access size code, log2 bytes (0..3)
- dreq_strobe  in  8  byte write enables; 0 means read
- dreq_wdata  in  64  store data
- dresp_ok  out  1  one-cycle pulse: data response valid
- dresp_data  out  64  load data
- bus_valid  out  1  bus request
- bus_addr  out  64  latched address
- bus_size  out  3  latched size
- bus_strobe  out  8  latched strobe
- bus_wdata  out  64  latched store data
- bus_ok  in  1  bus acknowledge, single beat
- bus_rdata  in  64  bus read data, valid with bus_ok

Behaviour:
- Reset (async, active-high):
  - state=IDLE, streak=0, kill=0.
  - All bus_* outputs 0; iresp_ok=0, dresp_ok=0; response data 0.
  - Reset mid-transaction abandons it. The bus side must tolerate bus_valid dropping on reset.
- FSM states:
  - IDLE: bus_valid=0. Sample requests; when one is selected, latch its fields into the bus registers and go to BUSY_I or BUSY_D. bus_valid rises the next cycle, so grant latency is 1 cycle.
  - BUSY_I: bus_valid=1, size=2 (4 bytes), strobe=0, wdata=0.
  - BUSY_D: bus_valid=1 with the latched dreq fields.
  - In BUSY_* on bus_ok: pulse the owner's *_ok combinationally in the same cycle, then return to IDLE.
  - No new grant in the same cycle as bus_ok. Minimum gap between bus transactions is one IDLE cycle.
- Bus outputs are held stable for the whole BUSY state, regardless of requester inputs changing.
- Selection in IDLE:
  - Only dreq_valid: grant D.
  - Only ireq_valid and not i_abort: grant I.
  - Both pending and streak<MAX_D_STREAK: grant D and increment streak.
  - Both pending and streak==MAX_D_STREAK: grant I and clear streak.
  - Any I grant clears streak.
  - A D grant with no fetch pending sets streak=0; streak counts only contended D grants.
  - streak never exceeds MAX_D_STREAK.
- Abort:
  - i_abort in IDLE: the fetch is not granted that cycle.
  - i_abort in BUSY_I: set kill. The transaction runs to bus_ok, but iresp_ok stays 0.
  - kill clears when leaving BUSY_I.
  - i_abort in BUSY_I in the same cycle as bus_ok: the response is suppressed.
  - i_abort in BUSY_D: no effect.
- iresp_data selection: bus_ok in BUSY_I returns bus_rdata[63:32] if latched addr[2]=1, else bus_rdata[31:0].
- dresp_data = bus_rdata, unshifted. The memory stage does alignment.
- Response data outputs are zero when their ok is 0.
- Requester drops valid in the cycle after ok. A valid still high in that cycle is treated as a new request.

Decomposition:
- Shared package (alongside the pipeline types):
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}
  - mem_req_t packed struct {addr, size, strobe, wdata}
  - MSIZE4=3'd2 constant
- One natural sub-module: arb_streak_ctr, the saturating streak counter with clear/increment and an at_limit output.

Test Plan:
- Single fetch: ireq addr 0x8000_0004. Bus_valid high at cycle+1. bus_ok with rdata 0x0010_0093_0000_0013 -> iresp_ok one cycle, iresp_data 0x0010_0093, bus_size=2, strobe=0.
- Simultaneous I and D requests: D (addr 0x8000_1000, strobe 0xFF, wdata 0xDEAD) is granted first with the fields exact. I is granted only after the IDLE gap.
- Starvation, MAX_D_STREAK=4: D held continuously with I pending -> grant order D,D,D,D,I,D...
- Abort in flight: i_abort pulsed mid BUSY_I -> bus completes, iresp_ok stays 0, next fetch granted normally.
- Abort coinciding with bus_ok -> no iresp_ok.
- Async reset asserted mid BUSY_D -> bus_valid and dresp_ok drop immediately with no clock edge; state IDLE and streak 0 after release.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } mem_req_t;

  // Instruction fetches are always 4-byte reads.
  localparam logic [2:0] MSIZE4 = 3'd2;

  // Pick the 32-bit instruction word out of a 64-bit bus beat.
  function automatic logic [31:0] sel_word(input logic [63:0] rdata, input logic hi);
    return hi ? rdata[63:32] : rdata[31:0];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_streak_ctr.sv
// Saturating counter of consecutive contended data grants.
module arb_streak_ctr #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  logic [3:0] r_count;

  assign o_at_limit = (r_count >= 4'(MAX_D_STREAK));

  // Clear wins over increment; increment stops at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_at_limit) begin
      r_count <= r_count + 4'd1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter (fetch and data) for the core's single memory bus.
module mem_bus_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  input  logic        i_abort,
  output logic        iresp_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_wdata,
  output logic        dresp_ok,
  output logic [63:0] dresp_data,
  output logic        bus_valid,
  output logic [63:0] bus_addr,
  output logic [2:0]  bus_size,
  output logic [7:0]  bus_strobe,
  output logic [63:0] bus_wdata,
  input  logic        bus_ok,
  input  logic [63:0] bus_rdata
);

  import mem_bus_arbiter_pkg::*;

  arb_state_t r_state;
  mem_req_t   r_req;
  logic       r_bus_valid;
  logic       r_kill;

  logic w_i_pend;
  logic w_at_limit;
  logic w_grant_i;
  logic w_grant_d;
  logic w_streak_inc;
  logic w_streak_clr;

  // A fetch that is being aborted this cycle is not a candidate.
  assign w_i_pend  = ireq_valid & ~i_abort;

  // Data wins unless fetch has waited through MAX_D_STREAK contended data grants.
  assign w_grant_d = (r_state == IDLE) & dreq_valid & ~(w_i_pend & w_at_limit);
  assign w_grant_i = (r_state == IDLE) & w_i_pend & (~dreq_valid | w_at_limit);

  // Only data grants that made a fetch wait extend the streak.
  assign w_streak_inc = w_grant_d & w_i_pend;
  assign w_streak_clr = w_grant_i | (w_grant_d & ~w_i_pend);

  arb_streak_ctr #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_streak (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_streak_clr),
    .i_inc      (w_streak_inc),
    .o_at_limit (w_at_limit)
  );

  // Arbitration FSM: latch the winner, hold it on the bus until bus_ok.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_bus_valid <= 1'b0;
      r_kill      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_kill <= 1'b0;
          if (w_grant_d) begin
            r_req       <= '{addr: dreq_addr, size: dreq_size,
                             strobe: dreq_strobe, wdata: dreq_wdata};
            r_bus_valid <= 1'b1;
            r_state     <= BUSY_D;
          end else if (w_grant_i) begin
            r_req       <= '{addr: ireq_addr, size: MSIZE4,
                             strobe: 8'h00, wdata: 64'h0};
            r_bus_valid <= 1'b1;
            r_state     <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (bus_ok) begin
            r_bus_valid <= 1'b0;
            r_kill      <= 1'b0;
            r_state     <= IDLE;
          end else if (i_abort) begin
            // The bus beat still completes; only the response is dropped.
            r_kill <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus_ok) begin
            r_bus_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_bus_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus_valid  = r_bus_valid;
  assign bus_addr   = r_req.addr;
  assign bus_size   = r_req.size;
  assign bus_strobe = r_req.strobe;
  assign bus_wdata  = r_req.wdata;

  // Responses are routed combinationally in the bus_ok cycle; abort in that cycle still suppresses.
  assign iresp_ok   = (r_state == BUSY_I) & bus_ok & ~r_kill & ~i_abort;
  assign dresp_ok   = (r_state == BUSY_D) & bus_ok;
  assign iresp_data = iresp_ok ? sel_word(bus_rdata, r_req.addr[2]) : 32'h0;
  assign dresp_data = dresp_ok ? bus_rdata : 64'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: transaction-level model plus decoupled monitor.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = '0;
  logic        i_abort = 1'b0;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid = 1'b0;
  logic [63:0] dreq_addr = '0;
  logic [2:0]  dreq_size = '0;
  logic [7:0]  dreq_strobe = '0;
  logic [63:0] dreq_wdata = '0;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [2:0]  bus_size;
  logic [7:0]  bus_strobe;
  logic [63:0] bus_wdata;
  logic        bus_ok = 1'b0;
  logic [63:0] bus_rdata = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .i_abort(i_abort),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_strobe(bus_strobe), .bus_wdata(bus_wdata),
    .bus_ok(bus_ok), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } rsp_exp_t;

  bus_exp_t exp_bus[$];
  rsp_exp_t exp_i[$];
  rsp_exp_t exp_d[$];
  int       resp_log[$];   // 1 = fetch response seen, 2 = data response seen

  // Reference model state (transaction level).
  int          m_owner = 0;      // owner for the next cycle: 0 none, 1 fetch, 2 data
  int          m_cur_owner = 0;  // owner during the current cycle
  int          m_streak = 0;
  bit          m_kill = 0;
  logic [63:0] m_iaddr = '0;

  // Requester agents.
  bit          i_pend = 0, d_pend = 0, d_auto = 0;
  bit          i_done = 0, d_done = 0;
  logic [63:0] a_iaddr = '0, a_daddr = '0, a_dwdata = '0;
  logic [2:0]  a_dsize = '0;
  logic [7:0]  a_dstrobe = '0;

  bit          mon_en = 0;
  logic        prev_bv = 1'b0;
  bus_exp_t    cur_bus;
  logic [31:0] last_idata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic issue_i(input logic [63:0] addr);
    i_pend  = 1;
    a_iaddr = addr;
  endtask

  task automatic issue_d(input logic [63:0] addr, input logic [2:0] size,
                         input logic [7:0] strobe, input logic [63:0] wdata);
    d_pend    = 1;
    a_daddr   = addr;
    a_dsize   = size;
    a_dstrobe = strobe;
    a_dwdata  = wdata;
  endtask

  // Apply the arbitration rules to the inputs present this cycle.
  task automatic model_eval();
    bus_exp_t be;
    rsp_exp_t re;
    bit ip, dp;
    m_cur_owner = m_owner;
    i_done = 0;
    d_done = 0;
    if (m_owner == 1) begin
      if (bus_ok) begin
        if (!m_kill && !i_abort) begin
          re.cyc  = cyc;
          re.data = m_iaddr[2] ? {32'h0, bus_rdata[63:32]} : {32'h0, bus_rdata[31:0]};
          exp_i.push_back(re);
          i_done = 1;
        end
        m_owner = 0;
        m_kill  = 0;
      end else if (i_abort) begin
        m_kill = 1;
      end
    end else if (m_owner == 2) begin
      if (bus_ok) begin
        re.cyc  = cyc;
        re.data = bus_rdata;
        exp_d.push_back(re);
        d_done  = 1;
        m_owner = 0;
      end
    end else begin
      ip = i_pend && !i_abort;
      dp = d_pend;
      be.cyc = cyc + 1;
      if (dp && (!ip || m_streak < MAXS)) begin
        m_streak  = ip ? m_streak + 1 : 0;
        be.addr   = a_daddr;
        be.size   = a_dsize;
        be.strobe = a_dstrobe;
        be.wdata  = a_dwdata;
        exp_bus.push_back(be);
        m_owner = 2;
      end else if (ip) begin
        m_streak  = 0;
        m_iaddr   = a_iaddr;
        be.addr   = a_iaddr;
        be.size   = 3'd2;
        be.strobe = 8'h00;
        be.wdata  = 64'h0;
        exp_bus.push_back(be);
        m_owner = 1;
      end
    end
  endtask

  // One clock: drive requesters, run the model, advance past the edge, retire requests.
  task automatic tick();
    ireq_valid  = i_pend;
    ireq_addr   = a_iaddr;
    dreq_valid  = d_pend;
    dreq_addr   = a_daddr;
    dreq_size   = a_dsize;
    dreq_strobe = a_dstrobe;
    dreq_wdata  = a_dwdata;
    model_eval();
    @(posedge clk);
    #1;
    if (i_done || i_abort) i_pend = 0;
    if (d_done) begin
      if (d_auto) a_dwdata = {$urandom(), $urandom()};
      else d_pend = 0;
    end
    i_abort   = 1'b0;
    bus_ok    = 1'b0;
    bus_rdata = '0;
  endtask

  // Wait for a grant, hold the bus for lat cycles, then acknowledge with rd.
  task automatic serve(input int lat, input logic [63:0] rd);
    int n = 0;
    while (m_owner == 0 && n < 20) begin
      tick();
      n++;
    end
    if (m_owner == 0) begin
      fail("serve_timeout: no grant within 20 cycles, a grant was required");
      return;
    end
    repeat (lat) tick();
    bus_ok    = 1'b1;
    bus_rdata = rd;
    tick();
  endtask

  // Monitor: compare DUT outputs with queued expectations, sampled on the falling edge.
  always @(negedge clk) begin
    bus_exp_t be;
    rsp_exp_t re;
    if (mon_en) begin
      check("bus_valid", 64'(bus_valid), 64'(m_cur_owner != 0));
      if (bus_valid && !prev_bv) begin
        if (exp_bus.size() == 0) begin
          fail("grant_unexpected");
        end else begin
          be = exp_bus.pop_front();
          check("grant_cycle", 64'(cyc), 64'(be.cyc));
          check("bus_addr", bus_addr, be.addr);
          check("bus_size", 64'(bus_size), 64'(be.size));
          check("bus_strobe", 64'(bus_strobe), 64'(be.strobe));
          check("bus_wdata", bus_wdata, be.wdata);
          cur_bus = be;
        end
      end else if (bus_valid) begin
        check("hold_addr", bus_addr, cur_bus.addr);
        check("hold_size", 64'(bus_size), 64'(cur_bus.size));
        check("hold_strobe", 64'(bus_strobe), 64'(cur_bus.strobe));
        check("hold_wdata", bus_wdata, cur_bus.wdata);
      end else if (exp_bus.size() > 0 && exp_bus[0].cyc <= cyc) begin
        be = exp_bus.pop_front();
        fail("grant_missing");
      end

      if (iresp_ok) begin
        resp_log.push_back(1);
        last_idata = iresp_data;
        if (exp_i.size() == 0) begin
          fail("iresp_unexpected");
        end else begin
          re = exp_i.pop_front();
          check("iresp_cycle", 64'(cyc), 64'(re.cyc));
          check("iresp_data", 64'(iresp_data), re.data);
        end
      end else begin
        check("iresp_data_zero", 64'(iresp_data), 64'h0);
        if (exp_i.size() > 0 && exp_i[0].cyc <= cyc) begin
          re = exp_i.pop_front();
          fail("iresp_missing");
        end
      end

      if (dresp_ok) begin
        resp_log.push_back(2);
        if (exp_d.size() == 0) begin
          fail("dresp_unexpected");
        end else begin
          re = exp_d.pop_front();
          check("dresp_cycle", 64'(cyc), 64'(re.cyc));
          check("dresp_data", dresp_data, re.data);
        end
      end else begin
        check("dresp_data_zero", dresp_data, 64'h0);
        if (exp_d.size() > 0 && exp_d[0].cyc <= cyc) begin
          re = exp_d.pop_front();
          fail("dresp_missing");
        end
      end
    end
    prev_bv <= mon_en ? bus_valid : 1'b0;
  end

  task automatic check_log(input string name, input int exp[]);
    check({name, "_len"}, 64'(resp_log.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < resp_log.size(); k++)
      check(name, 64'(resp_log[k]), 64'(exp[k]));
  endtask

  initial begin
    // Reset values
    #1 reset = 1'b1;
    #1;
    check("rst_bus_valid", 64'(bus_valid), 64'h0);
    check("rst_bus_addr", bus_addr, 64'h0);
    check("rst_bus_strobe", 64'(bus_strobe), 64'h0);
    check("rst_iresp_ok", 64'(iresp_ok), 64'h0);
    check("rst_dresp_ok", 64'(dresp_ok), 64'h0);
    check("rst_dresp_data", dresp_data, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1;

    // Single fetch, upper word selected by addr[2]
    resp_log.delete();
    issue_i(64'h8000_0004);
    serve(1, 64'h0010_0093_0000_0013);
    tick();
    check_log("single_fetch_order", '{1});
    check("single_fetch_data", 64'(last_idata), 64'h0010_0093);

    // Simultaneous fetch and data: data first, fetch after the idle gap
    resp_log.delete();
    issue_i(64'h8000_0008);
    issue_d(64'h8000_1000, 3'd3, 8'hFF, 64'hDEAD);
    serve(0, 64'h1111_2222_3333_4444);
    serve(2, 64'h5555_6666_7777_8888);
    tick();
    check_log("simul_order", '{2, 1});
    check("simul_fetch_lo_word", 64'(last_idata), 64'h7777_8888);

    // Starvation guard: data held continuously while a fetch waits
    resp_log.delete();
    d_auto = 1;
    issue_i(64'h8000_0000);
    issue_d(64'h8000_2000, 3'd3, 8'h00, 64'h0);
    for (int t = 0; t < 6; t++) begin
      if (t == 5) d_auto = 0;
      serve(0, {$urandom(), $urandom()});
    end
    tick();
    check_log("starve_order", '{2, 2, 2, 2, 1, 2});

    // Abort while the fetch is in flight, then a normal fetch
    resp_log.delete();
    issue_i(64'h8000_0010);
    tick();
    tick();
    i_abort = 1'b1;
    tick();
    serve(0, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    check_log("abort_inflight_none", '{});
    issue_i(64'h8000_0014);
    serve(1, 64'h0000_00EF_0000_0001);
    tick();
    check_log("after_abort_fetch", '{1});
    check("after_abort_data", 64'(last_idata), 64'h0000_00EF);

    // Abort in the same cycle as bus_ok
    resp_log.delete();
    issue_i(64'h8000_0020);
    tick();
    tick();
    i_abort   = 1'b1;
    bus_ok    = 1'b1;
    bus_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    tick();
    check_log("abort_with_ok_none", '{});

    // Randomized traffic
    for (int t = 0; t < 1500; t++) begin
      if (!i_pend && $urandom_range(3) == 0)
        issue_i({$urandom(), $urandom()} & ~64'h3);
      if (!d_pend && $urandom_range(2) == 0)
        issue_d({$urandom(), $urandom()}, 3'($urandom_range(3)),
                ($urandom_range(1) == 1) ? 8'($urandom()) : 8'h00,
                {$urandom(), $urandom()});
      i_abort = ($urandom_range(9) == 0);
      if (m_owner != 0 && $urandom_range(2) == 0) begin
        bus_ok    = 1'b1;
        bus_rdata = {$urandom(), $urandom()};
      end
      tick();
    end
    // Drain outstanding requests
    for (int t = 0; t < 40; t++) begin
      if (m_owner != 0) begin
        bus_ok    = 1'b1;
        bus_rdata = {$urandom(), $urandom()};
      end
      tick();
    end
    check("drain_bus_queue", 64'(exp_bus.size()), 64'h0);
    check("drain_i_queue", 64'(exp_i.size()), 64'h0);

    // Async reset in the middle of a data transaction with a fetch waiting
    issue_i(64'h8000_0040);
    issue_d(64'h8000_3000, 3'd2, 8'h0F, 64'h0BAD_F00D);
    begin
      int n = 0;
      while (m_owner != 2 && n < 20) begin
        tick();
        n++;
      end
    end
    mon_en    = 0;
    bus_ok    = 1'b1;
    bus_rdata = 64'hFEED_FACE_CAFE_BEEF;
    #1;
    check("pre_rst_bus_valid", 64'(bus_valid), 64'h1);
    check("pre_rst_dresp_ok", 64'(dresp_ok), 64'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_bus_valid", 64'(bus_valid), 64'h0);
    check("async_rst_dresp_ok", 64'(dresp_ok), 64'h0);
    check("async_rst_dresp_data", dresp_data, 64'h0);
    check("async_rst_bus_addr", bus_addr, 64'h0);
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    bus_ok     = 1'b0;
    i_pend = 0;
    d_pend = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_state_idle", 64'(dut.r_state), 64'(IDLE));
    check("rst_streak_zero", 64'(dut.u_streak.r_count), 64'h0);
    check("rst_kill_zero", 64'(dut.r_kill), 64'h0);
    @(negedge clk);
    check("post_rst_bus_valid", 64'(bus_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
